dvi_timing_ctrl: RTL and testbench

//   Video timing sequencer feeding the three per-channel TMDS encoders (B/G/R).

---
 rtl/dvi_timing_pkg.sv | 28 ++
 rtl/dvi_timing_ctrl_if.sv | 22 ++
 rtl/dvi_tpg_bars.sv | 22 ++
 rtl/dvi_timing_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_timing_pkg.sv
// Shared types and default 720p60 timing for the DVI timing sequencer.
// Holds the FSM state enum and the eight-bar colour table used by the pattern generator.
package dvi_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;
  localparam bit DEF_HS_POL   = 1'b1;
  localparam bit DEF_VS_POL   = 1'b1;

  // {R,G,B}; index 0 is the leftmost bar: W, Y, C, G, M, R, B, K.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/dvi_timing_ctrl_if.sv
// Pixel-request and encoder-side video bus of the timing sequencer.
// master = sequencer (requests pixels, drives encoders); slave = pixel source / encoder side.
interface dvi_timing_ctrl_if;
  logic        pix_req;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        vid_de;
  logic [23:0] vid_data;
  logic [2:0]  vid_c0;
  logic [2:0]  vid_c1;
  logic        sof;

  modport master (
    output pix_req, vid_de, vid_data, vid_c0, vid_c1, sof,
    input  pix_data, pix_valid
  );

  modport slave (
    input  pix_req, vid_de, vid_data, vid_c0, vid_c1, sof,
    output pix_data, pix_valid
  );
endinterface

// File: rtl/dvi_tpg_bars.sv
// Eight vertical colour bars across the active width: bar = h_cnt*8/H_ACTIVE.
// Purely combinational; the caller registers the result alongside the timing decode.
module dvi_tpg_bars
  import dvi_timing_pkg::*;
#(
  parameter int HW       = 11,
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [HW-1:0] h_cnt_i,
  output logic [23:0]   rgb_o
);

  localparam logic [HW+2:0] DIV = (HW+3)'(H_ACTIVE);

  logic [HW+2:0] h_x8;
  logic [2:0]    bar;

  assign h_x8  = {h_cnt_i, 3'b000};
  assign bar   = 3'(h_x8 / DIV);
  assign rgb_o = BAR_RGB[bar];

endmodule

// File: rtl/dvi_timing_ctrl.sv
// DVI timing sequencer: H/V counters, DE, HS/VS on blue c0/c1, pixel requests; counter-to-encoder latency 2 cycles.
// Upstream must answer each pix_req the next cycle (no backpressure); DVI_TPG_EN adds en_tpg and a colour-bar source.
module dvi_timing_ctrl
  import dvi_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              en,
`ifdef DVI_TPG_EN
  input  logic              en_tpg,
`endif
  input  logic              underflow_clr,
  output logic              busy,
  output logic              underflow,
  dvi_timing_ctrl_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HA_C   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VA_C   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          run, h_last, v_last;
  logic          active, hs, vs, sof_n;
  logic          tpg_on;
  logic [23:0]   tpg_rgb;

  // Slot as decoded in cycle N, held while the pixel arrives in N+1.
  logic          s1_act_q, s1_hs_q, s1_vs_q, s1_sof_q, s1_tpg_q;
  logic [23:0]   s1_rgb_q;

  logic          de_q, hs_q, vs_q, sof_q, underflow_q;
  logic [23:0]   data_q;
  logic [23:0]   data_d;
  logic          miss, underflow_d;

`ifdef DVI_TPG_EN
  assign tpg_on = en_tpg;

  dvi_tpg_bars #(
    .HW       (HW),
    .H_ACTIVE (H_ACTIVE)
  ) u_bars (
    .h_cnt_i (h_q),
    .rgb_o   (tpg_rgb)
  );
`else
  assign tpg_on  = 1'b0;
  assign tpg_rgb = '0;
`endif

  assign run    = (state_q != IDLE);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // A frame only ends from DRAIN at its last pixel, so stopping never truncates it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                  state_d = RUN;
        else if (h_last && v_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (run) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign active = run & (h_q < HA_C) & (v_q < VA_C);
  assign hs     = run & (h_q >= HS_BEG) & (h_q < HS_END);
  assign vs     = run & (v_q >= VS_BEG) & (v_q < VS_END);
  assign sof_n  = active & (h_q == '0) & (v_q == '0);

  // Bars replace the upstream source entirely, so no pixel is requested for them.
  assign miss        = s1_act_q & ~s1_tpg_q & ~vid.pix_valid;
  assign underflow_d = miss | (underflow_q & ~underflow_clr);

  always_comb begin
    data_d = '0;
    if (s1_act_q) begin
      if (s1_tpg_q)           data_d = s1_rgb_q;
      else if (vid.pix_valid) data_d = vid.pix_data;
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      s1_act_q    <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_tpg_q    <= 1'b0;
      s1_rgb_q    <= '0;
      de_q        <= 1'b0;
      data_q      <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      sof_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_act_q    <= active;
      s1_hs_q     <= hs;
      s1_vs_q     <= vs;
      s1_sof_q    <= sof_n;
      s1_tpg_q    <= tpg_on;
      s1_rgb_q    <= tpg_rgb;
      de_q        <= s1_act_q;
      data_q      <= data_d;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
      sof_q       <= s1_sof_q;
      underflow_q <= underflow_d;
    end
  end

  // Syncs are held active-high internally; polarity applied only at the pins.
  assign vid.pix_req  = active & ~tpg_on;
  assign vid.vid_de   = de_q;
  assign vid.vid_data = data_q;
  assign vid.vid_c0   = {2'b00, hs_q ~^ HS_POL};
  assign vid.vid_c1   = {2'b00, vs_q ~^ VS_POL};
  assign vid.sof      = sof_q;
  assign busy         = run;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Randomized bench for dvi_timing_ctrl on a tiny 8x6 raster against a frame-position reference model.
`timescale 1ns/1ps
module tb_dvi_timing_ctrl;

  localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic pix_clk       = 1'b0;
  logic rstn          = 1'b0;
  logic en            = 1'b1;
  logic underflow_clr = 1'b0;
  logic busy;
  logic underflow;
`ifdef DVI_TPG_EN
  logic en_tpg = 1'b0;
`endif

  dvi_timing_ctrl_if vif ();

  dvi_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VB),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .pix_clk       (pix_clk),
    .rstn          (rstn),
    .en            (en),
`ifdef DVI_TPG_EN
    .en_tpg        (en_tpg),
`endif
    .underflow_clr (underflow_clr),
    .busy          (busy),
    .underflow     (underflow),
    .vid           (vif)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        sof;
    logic        tpg;
    logic [23:0] rgb;
  } slot_t;

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_sof = -1, sof_gap = 0, sof_cnt = 0, ramp = 0;
  bit m_busy = 1'b0, m_en_prev = 1'b0, req_prev = 1'b0;
  int m_p = 0;
  slot_t r_prev = '0;
  logic e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_sof = 1'b0, e_ufl = 1'b0;
  logic [23:0] e_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int b);
    case (b)
      0:       return 24'hFFFFFF; // white
      1:       return 24'hFFFF00; // yellow
      2:       return 24'h00FFFF; // cyan
      3:       return 24'h00FF00; // green
      4:       return 24'hFF00FF; // magenta
      5:       return 24'hFF0000; // red
      6:       return 24'h0000FF; // blue
      default: return 24'h000000; // black
    endcase
  endfunction

  // One pixel clock: check what the DUT shows now, drive this cycle's inputs, advance the model.
  task automatic tick(input bit en_v, input bit miss, input bit clr_v, input bit tpg_v);
    slot_t cur;
    bit    stop;
    int    h, v;
    @(negedge pix_clk);
    cyc++;
    check_eq("busy",      32'(busy),         32'(m_busy));
    check_eq("vid_de",    32'(vif.vid_de),   32'(e_de));
    check_eq("vid_data",  32'(vif.vid_data), 32'(e_data));
    check_eq("vid_c0",    32'(vif.vid_c0),   32'({2'b00, e_hs}));
    check_eq("vid_c1",    32'(vif.vid_c1),   32'({2'b00, e_vs}));
    check_eq("sof",       32'(vif.sof),      32'(e_sof));
    check_eq("underflow", 32'(underflow),    32'(e_ufl));
    if (vif.sof === 1'b1) begin
      if (last_sof >= 0) sof_gap = cyc - last_sof;
      last_sof = cyc;
      sof_cnt++;
    end

    en            = en_v;
    underflow_clr = clr_v;
`ifdef DVI_TPG_EN
    en_tpg        = tpg_v;
`endif
    if (req_prev) begin
      vif.pix_data  = 24'(ramp);
      ramp++;
      vif.pix_valid = ~miss;
    end else begin
      vif.pix_data  = 24'($urandom);
      vif.pix_valid = 1'($urandom_range(0, 1));
    end

    h = m_p % HT;
    v = m_p / HT;
    cur.act = m_busy && (h < HA) && (v < VA);
    cur.hs  = m_busy && (h >= HA + HF) && (h < HA + HF + HSY);
    cur.vs  = m_busy && (v >= VA + VF) && (v < VA + VF + VSY);
    cur.sof = m_busy && (m_p == 0);
    cur.tpg = tpg_v;
    cur.rgb = bar_colour(h * 8 / HA);
    #1;
    check_eq("pix_req", 32'(vif.pix_req), 32'(cur.act && !tpg_v));

    e_de  = r_prev.act;
    e_hs  = r_prev.hs;
    e_vs  = r_prev.vs;
    e_sof = r_prev.sof;
    if (!r_prev.act)     e_data = '0;
    else if (r_prev.tpg) e_data = r_prev.rgb;
    else                 e_data = vif.pix_valid ? vif.pix_data : 24'h0;
    e_ufl = (r_prev.act && !r_prev.tpg && !vif.pix_valid) || (e_ufl && !clr_v);
    req_prev = cur.act && !tpg_v;
    r_prev   = cur;

    // A frame stops only at its last pixel, and only if run was already withdrawn beforehand.
    if (!m_busy) begin
      m_p = 0;
      if (en_v) m_busy = 1'b1;
    end else begin
      stop   = !m_en_prev && !en_v && (m_p == FT - 1);
      m_p    = (m_p + 1) % FT;
      if (stop) m_busy = 1'b0;
    end
    m_en_prev = en_v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cnt0;
    bit en_r;
    vif.pix_data  = '0;
    vif.pix_valid = 1'b0;

    repeat (3) begin
      @(negedge pix_clk);
      check_eq("rst_pix_req", 32'(vif.pix_req),  32'(0));
      check_eq("rst_de",      32'(vif.vid_de),   32'(0));
      check_eq("rst_data",    32'(vif.vid_data), 32'(0));
      check_eq("rst_c0",      32'(vif.vid_c0),   32'(0));
      check_eq("rst_c1",      32'(vif.vid_c1),   32'(0));
      check_eq("rst_sof",     32'(vif.sof),      32'(0));
      check_eq("rst_busy",    32'(busy),         32'(0));
      check_eq("rst_ufl",     32'(underflow),    32'(0));
    end
    en   = 1'b0;
    rstn = 1'b1;

    // Continuous run, every pixel supplied.
    repeat (100) tick(1, 0, 0, 0);
    check_eq("sof_count", 32'(sof_cnt >= 2), 32'(1));
    check_eq("sof_gap",   32'(sof_gap),      32'(FT));

    // Single miss sets the flag; clear works alone; set wins over a simultaneous clear.
    k = 0;
    while (!req_prev && k < 100) begin tick(1, 0, 0, 0); k++; end
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 0);
    check_eq("ufl_set", 32'(underflow), 32'(1));
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 0);
    check_eq("ufl_clr", 32'(underflow), 32'(0));
    k = 0;
    while (!req_prev && k < 100) begin tick(1, 0, 0, 0); k++; end
    tick(1, 1, 1, 0);
    tick(1, 0, 0, 0);
    check_eq("ufl_set_wins", 32'(underflow), 32'(1));

    // Random misses and clears.
    repeat (300) tick(1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 0);

    // Drop run at the start of line 1: the frame must finish before going idle.
    k = 0;
    while (!(m_busy && m_p == HT) && k < 200) begin tick(1, 0, 0, 0); k++; end
    k = 0;
    while (busy === 1'b1 && k < 120) begin tick(0, 0, 0, 0); k++; end
    check_eq("drain_len",  32'(k),    32'(FT - HT + 1));
    check_eq("drain_idle", 32'(busy), 32'(0));
    repeat (6) tick(0, 0, 0, 0);

    // Restart, withdraw run mid-frame, re-raise during drain: frames stay back to back.
    cnt0 = sof_cnt;
    k = 0;
    while (sof_cnt == cnt0 && k < 100) begin tick(1, 0, 0, 0); k++; end
    k = 0;
    while (m_p != HT && k < 100) begin tick(1, 0, 0, 0); k++; end
    repeat (10) tick(0, 0, 0, 0);
    cnt0 = sof_cnt;
    k = 0;
    while (sof_cnt == cnt0 && k < 100) begin tick(1, 0, 0, 0); k++; end
    check_eq("resume_sof_seen", 32'(sof_cnt > cnt0), 32'(1));
    check_eq("resume_sof_gap",  32'(sof_gap),        32'(FT));

    // Random run toggling with misses.
    en_r = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      tick(en_r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 0);
    end

`ifdef DVI_TPG_EN
    // Colour bars: no requests, no underflow even with random pix_valid.
    tick(1, 0, 1, 0);
    repeat (100) tick(1, 0, 0, 1);
    check_eq("tpg_no_ufl", 32'(underflow), 32'(0));
    repeat (3) tick(1, 0, 0, 0);
`endif

    // Asynchronous reset mid-frame.
    repeat (13) tick(1, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_pix_req", 32'(vif.pix_req),  32'(0));
    check_eq("arst_de",      32'(vif.vid_de),   32'(0));
    check_eq("arst_data",    32'(vif.vid_data), 32'(0));
    check_eq("arst_c0",      32'(vif.vid_c0),   32'(0));
    check_eq("arst_c1",      32'(vif.vid_c1),   32'(0));
    check_eq("arst_busy",    32'(busy),         32'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
